// File: rtl/egg_pkg.sv
// rtl/egg_pkg.sv - shared state, color and LFSR definitions for the egg game
package egg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHOW  = 3'd3,
    ST_OVER  = 3'd4
  } egg_state_e;

  localparam logic [1:0] COLOR_NONE = 2'b00;
  localparam logic [1:0] COLOR_HIT  = 2'b01;
  localparam logic [1:0] COLOR_MISS = 2'b10;
  localparam logic [1:0] COLOR_OVER = 2'b11;

  // Taps 16,14,13,11 expressed on bit indices 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] one_hot16(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/egg_lfsr.sv
// rtl/egg_lfsr.sv - free-running 16-bit Fibonacci LFSR used to pick egg positions
module egg_lfsr (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  import egg_pkg::*;

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Shift left, feeding the XOR of the tapped bits into bit 0
  always_comb begin
    q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  // State register, reloaded with the seed on reset
  always_ff @(posedge clk) begin
    if (!rst) q_q <= seed;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/egg_scheduler.sv
// rtl/egg_scheduler.sv - whack-an-egg game scheduler: spawns eggs, scores keys, runs the game clock
module egg_scheduler #(
  parameter int          GAME_SECS  = 60,
  parameter int          HOLD_TICKS = 2,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        sure,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] position,
  output logic [5:0]  cnttime,
  output logic [4:0]  score,
  output logic [1:0]  color,
  output logic        correct,
  output logic        remake
);
  import egg_pkg::*;

  localparam logic [5:0] GAME_INIT = 6'(GAME_SECS);
  localparam logic [3:0] LIFE_INIT = 4'(HOLD_TICKS);

  egg_state_e  state_q, state_d;
  logic        sure_q, sure_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  life_q, life_d;
  logic [15:0] position_q, position_d;
  logic [5:0]  cnttime_q, cnttime_d;
  logic [4:0]  score_q, score_d;
  logic [1:0]  color_q, color_d;
  logic        correct_q, correct_d;
  logic        remake_q, remake_d;

  logic [15:0] lfsr;
  logic        unused_lfsr_hi;
  logic        start;
  logic        active;
  logic        time_up;
  logic        hit;
  logic [3:0]  spawn_idx;

  egg_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:4];

  // Shared event decode: start edge, game-clock expiry, hit, and the non-repeating spawn index
  always_comb begin
    start     = sure & ~sure_q;
    active    = (state_q == ST_SPAWN) || (state_q == ST_WAIT) || (state_q == ST_SHOW);
    time_up   = active && tick && (cnttime_q == 6'd1);
    hit       = (state_q == ST_WAIT) && key_valid && (key_code == idx_q);
    spawn_idx = (lfsr[3:0] == idx_q) ? lfsr[3:0] + 4'd1 : lfsr[3:0];
  end

  // Next-state logic; running out of game time overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (start) state_d = ST_SPAWN;
      ST_SPAWN:         state_d = ST_WAIT;
      ST_WAIT: begin
        if (key_valid)                        state_d = ST_SHOW;
        else if (tick && (life_q == 4'd1))    state_d = ST_SHOW;
      end
      ST_SHOW:          if (tick) state_d = ST_SPAWN;
      default:          state_d = ST_IDLE;
    endcase
    if (time_up) state_d = ST_OVER;
  end

  // Output and datapath updates; a key press in WAIT takes priority over the egg lifetime tick
  always_comb begin
    sure_d     = sure;
    idx_d      = idx_q;
    life_d     = life_q;
    position_d = position_q;
    cnttime_d  = cnttime_q;
    score_d    = score_q;
    color_d    = color_q;
    correct_d  = 1'b0;
    remake_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          cnttime_d  = GAME_INIT;
          score_d    = 5'd0;
          color_d    = COLOR_NONE;
          position_d = 16'd0;
          remake_d   = 1'b1;
        end
      end
      ST_SPAWN: begin
        idx_d      = spawn_idx;
        position_d = one_hot16(spawn_idx);
        life_d     = LIFE_INIT;
      end
      ST_WAIT: begin
        if (key_valid) begin
          if (hit) begin
            correct_d = 1'b1;
            score_d   = (score_q == 5'd31) ? 5'd31 : score_q + 5'd1;
            color_d   = COLOR_HIT;
          end else begin
            color_d   = COLOR_MISS;
          end
        end else if (tick) begin
          life_d = life_q - 4'd1;
          if (life_q == 4'd1) color_d = COLOR_MISS;
        end
      end
      ST_SHOW: begin
        if (tick) begin
          color_d    = COLOR_NONE;
          position_d = 16'd0;
        end
      end
      default: ;
    endcase
    if (active && tick) cnttime_d = cnttime_q - 6'd1;
    if (time_up) begin
      position_d = 16'd0;
      color_d    = COLOR_OVER;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sure_q     <= 1'b0;
      idx_q      <= 4'd0;
      life_q     <= 4'd0;
      position_q <= 16'd0;
      cnttime_q  <= 6'd0;
      score_q    <= 5'd0;
      color_q    <= COLOR_NONE;
      correct_q  <= 1'b0;
      remake_q   <= 1'b0;
    end else begin
      sure_q     <= sure_d;
      idx_q      <= idx_d;
      life_q     <= life_d;
      position_q <= position_d;
      cnttime_q  <= cnttime_d;
      score_q    <= score_d;
      color_q    <= color_d;
      correct_q  <= correct_d;
      remake_q   <= remake_d;
    end
  end

  assign position = position_q;
  assign cnttime  = cnttime_q;
  assign score    = score_q;
  assign color    = color_q;
  assign correct  = correct_q;
  assign remake   = remake_q;

endmodule

// File: tb/tb_egg_scheduler.sv
// tb/tb_egg_scheduler.sv - self-checking bench for egg_scheduler against a game-level model
module tb_egg_scheduler;

  localparam int GS   = 60;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        sure = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] position;
  logic [5:0]  cnttime;
  logic [4:0]  score;
  logic [1:0]  color;
  logic        correct;
  logic        remake;

  int checks = 0;
  int errors = 0;

  egg_scheduler #(.GAME_SECS(GS), .HOLD_TICKS(HOLD), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .sure(sure), .key_valid(key_valid),
    .key_code(key_code), .position(position), .cnttime(cnttime), .score(score),
    .color(color), .correct(correct), .remake(remake)
  );

  always #5 clk = ~clk;

  // Game-level reference model
  localparam int P_IDLE = 0, P_SPAWN = 1, P_WAIT = 2, P_SHOW = 3, P_OVER = 4;
  int          m_phase;
  int          m_life;
  int          m_cnt;
  int          m_score;
  int          m_color;
  int          m_egg;
  int          m_prev;
  bit          m_sure;
  bit          m_correct;
  bit          m_remake;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] m_pos();
    if (m_egg < 0) return 16'd0;
    return 16'(1 << m_egg);
  endfunction

  task automatic model_step(input bit r, input bit s, input bit t, input bit kv, input int kc);
    int  old;
    bit  start;
    bit  fb;
    if (!r) begin
      m_phase = P_IDLE; m_life = 0; m_cnt = 0; m_score = 0; m_color = 0;
      m_egg = -1; m_prev = 0; m_sure = 0; m_correct = 0; m_remake = 0;
      m_lfsr = 16'hACE1;
      return;
    end
    old = m_phase;
    start = s && !m_sure;
    m_correct = 0;
    m_remake = 0;
    if (old == P_IDLE || old == P_OVER) begin
      if (start) begin
        m_cnt = GS; m_score = 0; m_color = 0; m_egg = -1; m_remake = 1; m_phase = P_SPAWN;
      end
    end else if (old == P_SPAWN) begin
      m_egg = m_lfsr % 16;
      if (m_egg == m_prev) m_egg = (m_egg + 1) % 16;
      m_prev = m_egg;
      m_life = HOLD;
      m_phase = P_WAIT;
    end else if (old == P_WAIT) begin
      if (kv) begin
        if (kc == m_egg) begin
          m_correct = 1;
          m_score = (m_score + 1 > 31) ? 31 : m_score + 1;
          m_color = 1;
        end else begin
          m_color = 2;
        end
        m_phase = P_SHOW;
      end else if (t) begin
        m_life = m_life - 1;
        if (m_life == 0) begin m_color = 2; m_phase = P_SHOW; end
      end
    end else if (old == P_SHOW) begin
      if (t) begin m_color = 0; m_egg = -1; m_phase = P_SPAWN; end
    end
    if ((old == P_SPAWN || old == P_WAIT || old == P_SHOW) && t) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_phase = P_OVER; m_egg = -1; m_color = 3; end
    end
    m_sure = s;
    fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
  endtask

  task automatic compare_model();
    checks++;
    if (position !== m_pos() || cnttime !== 6'(m_cnt) || score !== 5'(m_score) ||
        color !== 2'(m_color) || correct !== m_correct || remake !== m_remake) begin
      errors++;
      $display("FAIL model t=%0t got pos=%h cnt=%0d sc=%0d col=%0d cor=%0b rem=%0b want pos=%h cnt=%0d sc=%0d col=%0d cor=%0b rem=%0b",
               $time, position, cnttime, score, color, correct, remake,
               m_pos(), m_cnt, m_score, m_color, m_correct, m_remake);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit t, input bit kv, input logic [3:0] kc);
    rst = r; sure = s; tick = t; key_valid = kv; key_code = kc;
    @(posedge clk);
    model_step(r, s, t, kv, int'(kc));
    #1;
    compare_model();
    tick = 1'b0;
    key_valid = 1'b0;
  endtask

  function automatic logic [3:0] hit_code();
    return 4'(m_egg);
  endfunction

  function automatic logic [3:0] miss_code();
    return 4'(m_egg + 1);
  endfunction

  typedef struct {
    bit r, s, t, kv, khit;
    int e_cnt, e_score, e_color, e_cor, e_rem, e_bits;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [15:0] saved_pos;
    bit          reached;

    //             r  s  t  kv hit cnt sc col cor rem bits
    vecs[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0, 60, 0, 0, 0, 1, 0};
    vecs[3]  = '{1, 1, 0, 0, 0, 60, 0, 0, 0, 0, 1};
    vecs[4]  = '{1, 1, 0, 1, 1, 60, 1, 1, 1, 0, 1};
    vecs[5]  = '{1, 1, 0, 0, 0, 60, 1, 1, 0, 0, 1};
    vecs[6]  = '{1, 1, 1, 0, 0, 59, 1, 0, 0, 0, 0};
    vecs[7]  = '{1, 1, 0, 0, 0, 59, 1, 0, 0, 0, 1};
    vecs[8]  = '{1, 1, 1, 0, 0, 58, 1, 0, 0, 0, 1};
    vecs[9]  = '{1, 1, 1, 0, 0, 57, 1, 2, 0, 0, 1};
    vecs[10] = '{1, 1, 1, 0, 0, 56, 1, 0, 0, 0, 0};
    vecs[11] = '{1, 1, 0, 0, 0, 56, 1, 0, 0, 0, 1};
    vecs[12] = '{1, 1, 0, 1, 0, 56, 1, 2, 0, 0, 1};
    vecs[13] = '{1, 0, 1, 0, 0, 55, 1, 0, 0, 0, 0};

    saved_pos = 16'd0;
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].t, vecs[i].kv, vecs[i].khit ? hit_code() : miss_code());
      check_val($sformatf("vec%0d_cnttime", i), int'(cnttime), vecs[i].e_cnt);
      check_val($sformatf("vec%0d_score", i), int'(score), vecs[i].e_score);
      check_val($sformatf("vec%0d_color", i), int'(color), vecs[i].e_color);
      check_val($sformatf("vec%0d_correct", i), int'(correct), vecs[i].e_cor);
      check_val($sformatf("vec%0d_remake", i), int'(remake), vecs[i].e_rem);
      check_val($sformatf("vec%0d_pos_bits", i), $countones(position), vecs[i].e_bits);
      if (i == 5) saved_pos = position;
      if (i == 7) check_val("new_egg_differs", int'(position != saved_pos), 1);
    end

    // Mid-game reset with score 5, then a clean restart and saturation at 31
    cycle(0, 0, 0, 0, 4'd0);
    cycle(1, 0, 0, 0, 4'd0);
    cycle(1, 1, 0, 0, 4'd0);
    reached = 0;
    for (int n = 0; n < 400 && !reached; n++) begin
      if (m_phase == P_WAIT && m_score == 5) reached = 1;
      else if (m_phase == P_WAIT) cycle(1, 1, 0, 1, hit_code());
      else cycle(1, 1, m_phase == P_SHOW, 0, 4'd0);
    end
    check_val("reach_score5", int'(reached), 1);
    check_val("score_before_reset", int'(score), 5);
    cycle(0, 0, 0, 0, 4'd0);
    check_val("rst_position", int'(position), 0);
    check_val("rst_cnttime", int'(cnttime), 0);
    check_val("rst_score", int'(score), 0);
    check_val("rst_color", int'(color), 0);
    check_val("rst_flags", int'({correct, remake}), 0);
    cycle(1, 0, 0, 0, 4'd0);
    cycle(1, 1, 0, 0, 4'd0);
    check_val("restart_remake", int'(remake), 1);
    check_val("restart_cnttime", int'(cnttime), 60);
    check_val("restart_score", int'(score), 0);
    reached = 0;
    for (int n = 0; n < 800 && !reached; n++) begin
      if (m_phase == P_WAIT && m_score == 31) reached = 1;
      else if (m_phase == P_WAIT) cycle(1, 1, 0, 1, hit_code());
      else cycle(1, 1, m_phase == P_SHOW, 0, 4'd0);
    end
    check_val("reach_score31", int'(reached), 1);
    cycle(1, 1, 0, 1, hit_code());
    check_val("sat_score", int'(score), 31);
    check_val("sat_correct", int'(correct), 1);

    // Hit and final tick in the same cycle: hit counts, game ends
    cycle(0, 0, 0, 0, 4'd0);
    cycle(1, 1, 0, 0, 4'd0);
    reached = 0;
    for (int n = 0; n < 800 && !reached; n++) begin
      if (m_phase == P_WAIT && m_cnt == 1) reached = 1;
      else if (m_phase == P_WAIT) cycle(1, 1, 0, 1, miss_code());
      else cycle(1, 1, m_phase == P_SHOW, 0, 4'd0);
    end
    check_val("reach_cnt1", int'(reached), 1);
    cycle(1, 1, 1, 1, hit_code());
    check_val("end_score", int'(score), 1);
    check_val("end_cnttime", int'(cnttime), 0);
    check_val("end_color", int'(color), 3);
    check_val("end_position", int'(position), 0);
    check_val("end_correct", int'(correct), 1);
    cycle(1, 1, 1, 1, 4'd0);
    check_val("over_hold_score", int'(score), 1);
    check_val("over_hold_color", int'(color), 3);

    // Randomized play against the model
    for (int n = 0; n < 4000; n++) begin
      bit r, s, t, kv;
      logic [3:0] kc;
      r  = ($urandom_range(0, 599) != 0);
      s  = ($urandom_range(0, 19) == 0) ? !sure : sure;
      t  = ($urandom_range(0, 3) == 0);
      kv = ($urandom_range(0, 2) == 0);
      kc = ($urandom_range(0, 1) == 0) ? hit_code() : 4'($urandom_range(0, 15));
      cycle(r, s, t, kv, kc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/egg_scheduler.md
EGG_SCHEDULER -- requirements
Module: egg_scheduler

Interface
REQ-001 The block SHALL take parameter GAME_SECS, default 60, as the game length in ticks (1..63).
REQ-002 The block SHALL take parameter HOLD_TICKS, default 2, as the egg lifetime in ticks (1..15).
REQ-003 The block SHALL take parameter SEED, default 16'hACE1, as the nonzero LFSR reset value.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 tick  in  1  one-cycle 1 Hz timing enable.
REQ-007 sure  in  1  start/restart button level, debounced upstream.
REQ-008 key_valid  in  1  one-cycle pulse: new keypad press.
REQ-009 key_code  in  4  index (0..15) of the pressed key, valid with key_valid.
REQ-010 position  out  16  one-hot lit egg; all zero = none.
REQ-011 cnttime  out  6  remaining game ticks.
REQ-012 score  out  5  hit count.
REQ-013 color  out  2  feedback: 00 none, 01 hit/green, 10 miss/red, 11 game over/yellow.
REQ-014 correct  out  1  one-cycle pulse on a hit.
REQ-015 remake  out  1  one-cycle pulse when a game (re)starts.

Function
REQ-016 The FSM SHALL have states IDLE, SPAWN, WAIT, SHOW, OVER.
REQ-017 A start SHALL be the rising edge of sure, detected with one registered copy of sure.
REQ-018 IDLE or OVER + start: next cycle cnttime=GAME_SECS, score=0, color=00, remake=1 for exactly one cycle, state=SPAWN.
REQ-019 SPAWN (one cycle): egg index = lfsr[3:0]; if equal to previous index, use (index+1) mod 16; position = one-hot(index); life=HOLD_TICKS; next state WAIT.
REQ-020 WAIT + key_valid with key_code==index: correct=1 one cycle, score+1 saturating at 31, color=01, next state SHOW.
REQ-021 WAIT + key_valid with wrong key_code: score unchanged, color=10, next state SHOW.
REQ-022 WAIT + tick with no key_valid: life decrements; at life 1->0, color=10, next state SHOW.
REQ-023 WAIT + key_valid and tick in the same cycle: the key SHALL win, and life SHALL not be decremented.
REQ-024 SHOW: position and color held; on the next tick, color=00, position=0, next state SPAWN.
REQ-025 In SPAWN/WAIT/SHOW, every tick SHALL decrement cnttime; on the cycle it reaches 0, next state OVER regardless of other events; a hit on that same cycle still scores.
REQ-026 OVER: position=0, color=11, cnttime=0, score held until start.
REQ-027 key_valid outside WAIT SHALL be ignored; start in SPAWN/WAIT/SHOW SHALL be ignored.
REQ-028 The LFSR SHALL be 16-bit Fibonacci, taps 16,14,13,11, advancing every clock including IDLE.

Reset
REQ-029 On rst=0 at a clock edge: state=IDLE, position=0, cnttime=0, score=0, color=00, correct=0, remake=0, lfsr=SEED, previous index=0, sure edge register=0.
REQ-030 Reset SHALL take effect mid-game with no partial update on that edge.

Structure
REQ-031 Package egg_pkg SHALL hold the state enum, the four color codes and the LFSR tap mask.
REQ-032 The LFSR SHALL be a sub-module egg_lfsr (clk, rst, seed, q[15:0]).

Verification
REQ-033 Reset, then sure 0->1 -> remake pulse, cnttime=60, score=0, exactly one position bit set two cycles later.
REQ-034 In WAIT, key_code equal to the lit index with key_valid -> correct pulse, score 0->1, color=01; after the next tick, a new egg differs from the old one.
REQ-035 No key for 2 ticks -> color=10, score unchanged; after 1 more tick -> new egg.
REQ-036 key_valid (hit) and tick in the same cycle with cnttime=1 -> score+1, cnttime=0, state OVER, color=11, position=0.
REQ-037 Score forced to 31 plus a hit -> score stays 31 and correct still pulses.
REQ-038 rst=0 asserted in WAIT with score=5 -> next cycle all outputs at reset values; a later sure edge starts a clean game.
